// File: rtl/hsk_tx_arbiter.sv
// hsk_tx_arbiter: round-robin merge of two COBS packet streams onto one byte stream.
// A stalled packet is closed with a 00 delimiter, and the rest of that packet is discarded.
module hsk_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 160000
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [7:0] s0_axis_tdata,
  input  logic       s0_axis_tvalid,
  output logic       s0_axis_tready,
  input  logic       s0_axis_tlast,
  input  logic [7:0] s1_axis_tdata,
  input  logic       s1_axis_tvalid,
  output logic       s1_axis_tready,
  input  logic       s1_axis_tlast,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic [1:0] grant,
  output logic [7:0] abort_count,
  output logic       abort_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PASS, ABORT} state_t;
  state_t state;
  logic last_served, sel, g_valid;
  logic [TW-1:0] timer;
  logic [1:0] discard, s_valid, s_last, s_ready, hs, elig;
  logic [7:0] g_data;
  assign s_valid = {s1_axis_tvalid, s0_axis_tvalid};
  assign s_last = {s1_axis_tlast, s0_axis_tlast};
  assign sel = grant[1];
  assign g_valid = s_valid[sel];
  assign g_data = sel ? s1_axis_tdata : s0_axis_tdata;
  // Discarding sources are drained in every state, including while their own delimiter is pending.
  assign s_ready = discard | ({2{state == PASS && m_axis_tready}} & grant);
  assign {s1_axis_tready, s0_axis_tready} = s_ready;
  assign hs = s_valid & s_ready;
  assign elig = s_valid & ~discard;
  assign m_axis_tvalid = state == ABORT || (state == PASS && g_valid);
  assign m_axis_tdata = state == PASS ? g_data : 8'h00;
  assign abort_o = state == ABORT && m_axis_tready;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      grant <= 2'b00;
      last_served <= 1'b1;
      timer <= '0;
      discard <= 2'b00;
      abort_count <= 8'h00;
    end else begin
      discard <= discard & ~(hs & s_last);
      case (state)
        IDLE: if (|elig) begin
          state <= PASS;
          timer <= '0;
          grant <= &elig ? (last_served ? 2'b01 : 2'b10) : elig;
        end
        PASS: if (hs[sel] && s_last[sel]) begin
          state <= IDLE;
          grant <= 2'b00;
          last_served <= sel;
        end else if (g_valid) begin
          timer <= '0;
        end else if (timer == T_LAST) begin
          state <= ABORT;
          discard[sel] <= 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
        ABORT: if (m_axis_tready) begin
          state <= IDLE;
          grant <= 2'b00;
          last_served <= sel;
          abort_count <= abort_count + {7'd0, abort_count != 8'hff};
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
